// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction cache block: FSM state
// encoding, address-field slicing and a log2 helper for derived widths.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      RESP
   } state_t;

   // Ceiling log2, used for index and way widths.
   function automatic int log2c(input int n);
      return $clog2(n);
   endfunction

   // Tag field: everything above the index and the byte offset.
   function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w);
      return addr >> (idx_w + 2);
   endfunction

   // Index field: the idx_w bits just above the byte offset.
   function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w);
      return (addr >> 2) & ((64'd1 << idx_w) - 64'd1);
   endfunction

endpackage

// File: rtl/icache_block_param_if.sv
// CPU-side and common-bus signals of the instruction cache block.
// slave  : the cache block itself.
// master : the CPU / bus environment that drives requests and fill data.
interface icache_block_param_if
   import icache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int WAYS   = 4
);
   localparam int WAY_W = log2c(WAYS);

   logic              PrRd;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] Data_out;
   logic              Data_valid;
   logic              CPU_stall;
   logic              Inv_all;
   logic              Com_Bus_Req;
   logic              Com_Bus_Gnt;
   logic [ADDR_W-1:0] Address_Com;
   logic              Address_Com_oe;
   logic [DATA_W-1:0] Data_Bus_Com;
   logic              Data_in_Bus;
   logic [WAY_W-1:0]  Blk_accessed;
   logic [31:0]       Hit_cnt;
   logic [31:0]       Miss_cnt;

   modport slave (
      input  PrRd, Address, Inv_all, Com_Bus_Gnt, Data_Bus_Com, Data_in_Bus,
      output Data_out, Data_valid, CPU_stall, Com_Bus_Req, Address_Com,
             Address_Com_oe, Blk_accessed, Hit_cnt, Miss_cnt
   );

   modport master (
      output PrRd, Address, Inv_all, Com_Bus_Gnt, Data_Bus_Com, Data_in_Bus,
      input  Data_out, Data_valid, CPU_stall, Com_Bus_Req, Address_Com,
             Address_Com_oe, Blk_accessed, Hit_cnt, Miss_cnt
   );

endinterface

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set. Nodes are heap-ordered (root 0, children
// 2n+1 / 2n+2); a node bit of 0 points the victim into the left subtree.
// Purely combinational: the caller stores the bits per set.
module plru_tree
   import icache_pkg::*;
#(
   parameter int  WAYS  = 4,
   localparam int WAY_W = log2c(WAYS)
)(
   input  logic [WAYS-2:0]  plru_bits,
   input  logic [WAY_W-1:0] access_way,
   output logic [WAYS-2:0]  next_bits,
   output logic [WAY_W-1:0] victim_way
);

   int   pos;
   logic dir;

   // Walk from the root following the node bits to find the victim leaf.
   always_comb begin
      pos = 0;
      dir = 1'b0;
      for (int l = 0; l < WAY_W; l++) begin
         dir = 1'b0;
         for (int p = 0; p < (1 << l); p++) begin
            if (pos == p) dir = plru_bits[(1 << l) - 1 + p];
         end
         pos = 2 * pos + int'(dir);
      end
      victim_way = WAY_W'(pos);
   end

   // Point every node on the accessed way's path away from that way.
   always_comb begin
      next_bits = plru_bits;
      for (int l = 0; l < WAY_W; l++) begin
         for (int p = 0; p < (1 << l); p++) begin
            if (int'(access_way >> (WAY_W - l)) == p)
               next_bits[(1 << l) - 1 + p] = ~access_way[WAY_W - 1 - l];
         end
      end
   end

endmodule

// File: rtl/icache_block_param.sv
// N-way set-associative read-only instruction cache, one word per line.
// Hits return data one cycle after the request; misses arbitrate for the
// common bus, fetch the word and fill a victim way (first invalid way,
// else tree pseudo-LRU).
// Optional feature: define ICACHE_STATS_EN to enable saturating hit/miss
// counters on Hit_cnt/Miss_cnt; otherwise both are tied to zero.
module icache_block_param
   import icache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int WAYS   = 4,
   parameter int SETS   = 256
)(
   input logic clk,
   input logic rst,
   icache_block_param_if.slave bus
);

   localparam int IDX_W = log2c(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam int WAY_W = log2c(WAYS);

   state_t state, next_state;

   logic [TAG_W-1:0]  a_tag, lat_tag;
   logic [IDX_W-1:0]  a_idx, lat_idx, set_idx;
   logic [WAYS-1:0]   hit_vec;
   logic [WAY_W-1:0]  hit_way, victim, victim_q, plru_way, acc_way;
   logic              hit, hit_now, miss_start, fill_now, clear_all, inv_pend;
   logic [WAYS-2:0]   plru_next;

   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [DATA_W-1:0] data_mem [SETS][WAYS];
   logic [WAYS-1:0]   valid    [SETS];
   logic [WAYS-2:0]   plru     [SETS];

   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic [WAY_W-1:0]  blk_accessed;
   logic              cpu_stall, com_bus_req, address_com_oe;
   logic [ADDR_W-1:0] address_com;

   assign a_tag = TAG_W'(addr_tag(64'(bus.Address), IDX_W));
   assign a_idx = IDX_W'(addr_index(64'(bus.Address), IDX_W));

   // Combinational tag compare on the live request address.
   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++)
         hit_vec[w] = valid[a_idx][w] && (tag_mem[a_idx][w] == a_tag);
      for (int w = WAYS - 1; w >= 0; w--)
         if (hit_vec[w]) hit_way = WAY_W'(w);
   end

   assign hit        = bus.PrRd && (|hit_vec);
   assign hit_now    = (state == IDLE) && hit;
   assign miss_start = (state == IDLE) && bus.PrRd && !hit;
   assign fill_now   = (state == FILL) && bus.Data_in_Bus;
   assign clear_all  = ((state == IDLE) && bus.Inv_all) ||
                       ((state == RESP) && (inv_pend || bus.Inv_all));

   // Victim: lowest-index invalid way, else the PLRU choice.
   always_comb begin
      victim = plru_way;
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid[a_idx][w]) victim = WAY_W'(w);
   end

   // The single PLRU instance looks at the request set in IDLE and at the
   // latched set while filling.
   assign set_idx = (state == FILL) ? lat_idx  : a_idx;
   assign acc_way = (state == FILL) ? victim_q : hit_way;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .plru_bits  (plru[set_idx]),
      .access_way (acc_way),
      .next_bits  (plru_next),
      .victim_way (plru_way)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state and combinational bus/stall outputs.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      next_state     = state;
      cpu_stall      = 1'b0;
      com_bus_req    = 1'b0;
      address_com_oe = 1'b0;
      address_com    = '0;
      unique case (state)
         IDLE: begin
            cpu_stall = miss_start;
            if (miss_start) next_state = REQ;
         end
         REQ: begin
            cpu_stall   = 1'b1;
            com_bus_req = 1'b1;
            if (bus.Com_Bus_Gnt) next_state = FILL;
         end
         FILL: begin
            cpu_stall      = 1'b1;
            com_bus_req    = 1'b1;
            address_com_oe = 1'b1;
            address_com    = {lat_tag, lat_idx, 2'b00};
            if (bus.Data_in_Bus)       next_state = RESP;
            else if (!bus.Com_Bus_Gnt) next_state = REQ;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Valid bits, PLRU state and the deferred flash-invalidate.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            plru[s]  <= '0;
         end
         inv_pend <= 1'b0;
      end else begin
         if (clear_all) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
         end else if (fill_now) begin
            valid[lat_idx][victim_q] <= 1'b1;
         end
         if (hit_now || fill_now) plru[set_idx] <= plru_next;
         if (state == RESP)                         inv_pend <= 1'b0;
         else if ((state != IDLE) && bus.Inv_all)   inv_pend <= 1'b1;
      end
   end

   // Miss context captured when leaving IDLE; only consumed in REQ/FILL.
   always_ff @(posedge clk) begin
      if (miss_start) begin
         lat_tag  <= a_tag;
         lat_idx  <= a_idx;
         victim_q <= victim;
      end
   end

   // Tag/data array write on fill completion.
   always_ff @(posedge clk) begin
      // NOTE: the arrays have no reset; cleared valid bits make stale contents
      // unreachable, and an unreset array can map onto RAM.
      if (!rst && fill_now) begin
         tag_mem[lat_idx][victim_q]  <= lat_tag;
         data_mem[lat_idx][victim_q] <= bus.Data_Bus_Com;
      end
   end

   // Registered CPU response for hits and completed fills.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out     <= '0;
         data_valid   <= 1'b0;
         blk_accessed <= '0;
      end else begin
         data_valid <= hit_now || fill_now;
         if (hit_now) begin
            data_out     <= data_mem[a_idx][hit_way];
            blk_accessed <= hit_way;
         end else if (fill_now) begin
            data_out     <= bus.Data_Bus_Com;
            blk_accessed <= victim_q;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;

   // Saturating hit/miss counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit_now && (hit_cnt != '1))     hit_cnt  <= hit_cnt + 32'd1;
         if (miss_start && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
      end
   end

   assign bus.Hit_cnt  = hit_cnt;
   assign bus.Miss_cnt = miss_cnt;
`else
   assign bus.Hit_cnt  = '0;
   assign bus.Miss_cnt = '0;
`endif

   assign bus.Data_out       = data_out;
   assign bus.Data_valid     = data_valid;
   assign bus.Blk_accessed   = blk_accessed;
   assign bus.CPU_stall      = cpu_stall;
   assign bus.Com_Bus_Req    = com_bus_req;
   assign bus.Address_Com    = address_com;
   assign bus.Address_Com_oe = address_com_oe;

endmodule

// File: tb/tb_icache_block_param.sv
// Scoreboard bench for icache_block_param: expected read responses are
// queued when a request is driven and compared when Data_valid pulses.
module tb_icache_block_param;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int WAYS   = 4;
   localparam int SETS   = 256;
   localparam int WAY_W  = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   icache_block_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS)) bus ();

   icache_block_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [WAY_W-1:0]  way;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_hits = 0;
   int   exp_misses = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Response monitor: every Data_valid pulse must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && bus.Data_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("rd_data", 64'(bus.Data_out), 64'(e.data));
            check("rd_way", 64'(bus.Blk_accessed), 64'(e.way));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst              = 1'b1;
      bus.PrRd         = 1'b0;
      bus.Address      = '0;
      bus.Inv_all      = 1'b0;
      bus.Com_Bus_Gnt  = 1'b0;
      bus.Data_Bus_Com = '0;
      bus.Data_in_Bus  = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      sb.delete();
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic check_stats();
`ifdef ICACHE_STATS_EN
      check("hit_cnt", 64'(bus.Hit_cnt), 64'(exp_hits));
      check("miss_cnt", 64'(bus.Miss_cnt), 64'(exp_misses));
`else
      check("hit_cnt", 64'(bus.Hit_cnt), 64'd0);
      check("miss_cnt", 64'(bus.Miss_cnt), 64'd0);
`endif
   endtask

   // Present a request for half a cycle only, check the stall decision.
   task automatic probe(input logic [31:0] addr, input logic exp_stall, input string tag);
      bus.PrRd    = 1'b1;
      bus.Address = addr;
      @(negedge clk);
      check(tag, 64'(bus.CPU_stall), 64'(exp_stall));
      #1;
      bus.PrRd = 1'b0;
      step();
   endtask

   task automatic read_hit(input logic [31:0] addr, input logic [31:0] data,
                           input logic [WAY_W-1:0] way, input logic inv);
      bus.PrRd    = 1'b1;
      bus.Address = addr;
      bus.Inv_all = inv;
      sb.push_back('{data: data, way: way});
      exp_hits++;
      @(negedge clk);
      check("hit_stall", 64'(bus.CPU_stall), 64'd0);
      check("hit_req", 64'(bus.Com_Bus_Req), 64'd0);
      step();
      bus.PrRd    = 1'b0;
      bus.Inv_all = 1'b0;
      step();
      check("hit_dv_missing", 64'(sb.size()), 64'd0);
   endtask

   // Miss request through REQ into the first FILL cycle.
   task automatic miss_to_fill(input logic [31:0] addr);
      bus.PrRd    = 1'b1;
      bus.Address = addr;
      exp_misses++;
      @(negedge clk);
      check("miss_stall", 64'(bus.CPU_stall), 64'd1);
      step();
      @(negedge clk);
      check("req_req", 64'(bus.Com_Bus_Req), 64'd1);
      check("req_oe", 64'(bus.Address_Com_oe), 64'd0);
      bus.Com_Bus_Gnt = 1'b1;
      step();
      @(negedge clk);
      check("fill_addr", 64'(bus.Address_Com), 64'(addr & 32'hFFFF_FFFC));
      check("fill_oe", 64'(bus.Address_Com_oe), 64'd1);
      check("fill_stall", 64'(bus.CPU_stall), 64'd1);
   endtask

   task automatic finish_fill(input logic [31:0] data);
      bus.Data_in_Bus  = 1'b1;
      bus.Data_Bus_Com = data;
      step();
      bus.Data_in_Bus  = 1'b0;
      bus.Com_Bus_Gnt  = 1'b0;
      bus.PrRd         = 1'b0;
      @(negedge clk);
      check("resp_stall", 64'(bus.CPU_stall), 64'd0);
      check("resp_req", 64'(bus.Com_Bus_Req), 64'd0);
      check("resp_oe", 64'(bus.Address_Com_oe), 64'd0);
      step();
      check("fill_dv_missing", 64'(sb.size()), 64'd0);
   endtask

   task automatic read_miss(input logic [31:0] addr, input logic [31:0] data,
                            input logic [WAY_W-1:0] way);
      sb.push_back('{data: data, way: way});
      miss_to_fill(addr);
      step();
      @(negedge clk);
      check("fill_hold_oe", 64'(bus.Address_Com_oe), 64'd1);
      finish_fill(data);
   endtask

   initial begin
      logic [31:0] tags_addr [5];
      logic [31:0] tags_data [5];
      tags_addr = '{32'h0000_0404, 32'h0000_0804, 32'h0000_0C04, 32'h0000_1404, 32'h0000_1804};
      tags_data = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004, 32'hE0E0_0005};

      do_reset();
      @(negedge clk);
      check("rst_dv", 64'(bus.Data_valid), 64'd0);
      check("rst_dout", 64'(bus.Data_out), 64'd0);
      check("rst_blk", 64'(bus.Blk_accessed), 64'd0);
      check("rst_stall", 64'(bus.CPU_stall), 64'd0);
      check("rst_req", 64'(bus.Com_Bus_Req), 64'd0);
      check("rst_oe", 64'(bus.Address_Com_oe), 64'd0);
      check("rst_addr_com", 64'(bus.Address_Com), 64'd0);
      check_stats();
      step();

      // Cold miss then hit on the same word.
      read_miss(32'h0000_1004, 32'hDEAD_BEEF, 2'd0);
      read_hit(32'h0000_1004, 32'hDEAD_BEEF, 2'd0, 1'b0);
      check_stats();

      // Eviction in set 1: fill A..D, touch A, miss on E -> PLRU picks way 2.
      do_reset();
      for (int i = 0; i < 4; i++) read_miss(tags_addr[i], tags_data[i], WAY_W'(i));
      read_hit(tags_addr[0], tags_data[0], 2'd0, 1'b0);
      read_miss(tags_addr[4], tags_data[4], 2'd2);
      read_hit(tags_addr[0], tags_data[0], 2'd0, 1'b0);
      read_hit(tags_addr[4], tags_data[4], 2'd2, 1'b0);
      read_hit(tags_addr[1], tags_data[1], 2'd1, 1'b0);
      read_hit(tags_addr[3], tags_data[3], 2'd3, 1'b0);
      probe(tags_addr[2], 1'b1, "evicted_miss");
      check_stats();

      // Grant drop mid-FILL: back to REQ, regrant completes the fill.
      sb.push_back('{data: 32'h1234_5678, way: 2'd0});
      miss_to_fill(32'h0000_0408);
      bus.Com_Bus_Gnt = 1'b0;
      step();
      @(negedge clk);
      check("gdrop_req", 64'(bus.Com_Bus_Req), 64'd1);
      check("gdrop_oe", 64'(bus.Address_Com_oe), 64'd0);
      check("gdrop_stall", 64'(bus.CPU_stall), 64'd1);
      check("gdrop_no_dv", 64'(bus.Data_valid), 64'd0);
      bus.Com_Bus_Gnt = 1'b1;
      step();
      @(negedge clk);
      check("regrant_oe", 64'(bus.Address_Com_oe), 64'd1);
      finish_fill(32'h1234_5678);
      read_hit(32'h0000_0408, 32'h1234_5678, 2'd0, 1'b0);

      // Invalidate during FILL: data still returned, everything misses after.
      sb.push_back('{data: 32'h5555_AAAA, way: 2'd0});
      miss_to_fill(32'h0000_080C);
      bus.Inv_all = 1'b1;
      step();
      bus.Inv_all = 1'b0;
      @(negedge clk);
      check("inv_fill_oe", 64'(bus.Address_Com_oe), 64'd1);
      finish_fill(32'h5555_AAAA);
      probe(32'h0000_080C, 1'b1, "inv_new_miss");
      probe(32'h0000_0408, 1'b1, "inv_old_miss");
      probe(tags_addr[0], 1'b1, "inv_a_miss");
      check_stats();

      // Invalidate in IDLE alongside a hit: hit served, line gone after.
      read_miss(tags_addr[0], tags_data[0], 2'd0);
      read_hit(tags_addr[0], tags_data[0], 2'd0, 1'b1);
      probe(tags_addr[0], 1'b1, "idle_inv_miss");

      // Reset mid-FILL aborts the transaction with no line written.
      miss_to_fill(32'h0000_0410);
      rst             = 1'b1;
      bus.PrRd        = 1'b0;
      bus.Com_Bus_Gnt = 1'b0;
      step();
      @(negedge clk);
      check("rstfill_req", 64'(bus.Com_Bus_Req), 64'd0);
      check("rstfill_stall", 64'(bus.CPU_stall), 64'd0);
      check("rstfill_oe", 64'(bus.Address_Com_oe), 64'd0);
      check("rstfill_dv", 64'(bus.Data_valid), 64'd0);
      rst = 1'b0;
      sb.delete();
      exp_hits   = 0;
      exp_misses = 0;
      step();
      probe(32'h0000_0410, 1'b1, "rstfill_miss");
      check_stats();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
